wb_port_arbiter: RTL and testbench

//  Shares the single ROB write-back port (WB_valid/WB_data/WB_rob_idx) between N_REQ

---
 rtl/wb_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single ROB write-back port between N_REQ functional units. Each FU
//   result lands in a one-entry holding register; one held result is granted per
//   cycle in round-robin order. Held and incoming results belonging to squashed ROB
//   entries are dropped on a mispredict. Also produces writeback_free for the ROB
//   issue/RR stage.
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid/_data/_rob_idx   per-FU result presentation (packed, slice per FU)
//   req_ready          holding register i can take a result this cycle
//   mispredict, flush_mask     squash request and the ROB entries it kills
//   WB_valid/_data/_rob_idx    write-back to the ROB (zeros when idle)
//   writeback_free     no slot will be eligible next cycle
//   grant_oh           one-hot id of the granted requester
module wb_port_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ROB_LEN = 16,
  localparam int unsigned IDX_W  = $clog2(ROB_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*32-1:0]    req_data,
  input  logic [N_REQ*IDX_W-1:0] req_rob_idx,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   mispredict,
  input  logic [ROB_LEN-1:0]     flush_mask,
  output logic                   WB_valid,
  output logic [31:0]            WB_data,
  output logic [IDX_W-1:0]       WB_rob_idx,
  output logic                   writeback_free,
  output logic [N_REQ-1:0]       grant_oh
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  r_held;
  logic [DATA_W-1:0] r_hdata [N_REQ];
  logic [IDX_W-1:0]  r_hidx  [N_REQ];
  logic [PTR_W-1:0]  r_rr_ptr;

  logic [N_REQ-1:0]  w_kill;
  logic [N_REQ-1:0]  w_sq_in;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_gidx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  w_ready;
  logic [N_REQ-1:0]  w_load;
  logic [N_REQ-1:0]  w_held_nxt;

  // Squash detection for held entries and for results arriving this cycle.
  always_comb begin
    w_kill  = '0;
    w_sq_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_kill[i]  = mispredict & r_held[i] & flush_mask[r_hidx[i]];
      w_sq_in[i] = mispredict & flush_mask[req_rob_idx[IDX_W*i +: IDX_W]];
    end
  end

  // Nothing is granted while reset is asserted, so the reset cycle never writes back.
  assign w_elig = r_held & ~w_kill & {N_REQ{~rst}};

  // Round-robin pick: first scan from rr_ptr upward, then wrap to the low indices.
  always_comb begin : p_pick
    logic found;
    found   = 1'b0;
    w_grant = '0;
    w_gidx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && w_elig[i] && (PTR_W'(i) >= r_rr_ptr)) begin
        found      = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = PTR_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && w_elig[i]) begin
        found      = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  // A granted slot empties this cycle, so it can refill without a bubble.
  assign w_ready = {N_REQ{rst}} | ~r_held | w_grant;
  assign w_load  = req_valid & w_ready & ~w_sq_in & {N_REQ{~rst}};

  // Next-state held bits: new accept wins over grant/kill clear.
  always_comb begin
    w_held_nxt = r_held;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rst) begin
        w_held_nxt[i] = 1'b0;
      end else if (w_load[i]) begin
        w_held_nxt[i] = 1'b1;
      end else if (w_grant[i] || w_kill[i]) begin
        w_held_nxt[i] = 1'b0;
      end
    end
  end

  // Write-back mux; all-zero when nothing is granted.
  always_comb begin
    WB_data    = '0;
    WB_rob_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        WB_data    = WB_data | r_hdata[i];
        WB_rob_idx = WB_rob_idx | r_hidx[i];
      end
    end
  end

  assign WB_valid       = |w_grant;
  assign grant_oh       = w_grant;
  assign req_ready      = w_ready;
  assign writeback_free = ~|w_held_nxt;

  // Control state: held flags and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_held <= w_held_nxt;
      if (|w_grant) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Payload registers; only meaningful while the matching held bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_load[i]) begin
        r_hdata[i] <= req_data[DATA_W*i +: DATA_W];
        r_hidx[i]  <= req_rob_idx[IDX_W*i +: IDX_W];
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int N  = 4;
  localparam int RL = 16;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_data;
  logic [N*IW-1:0] req_rob_idx;
  logic [N-1:0]    req_ready;
  logic            mispredict;
  logic [RL-1:0]   flush_mask;
  logic            WB_valid;
  logic [31:0]     WB_data;
  logic [IW-1:0]   WB_rob_idx;
  logic            writeback_free;
  logic [N-1:0]    grant_oh;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.N_REQ(N), .ROB_LEN(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_rob_idx(req_rob_idx),
    .req_ready(req_ready), .mispredict(mispredict), .flush_mask(flush_mask),
    .WB_valid(WB_valid), .WB_data(WB_data), .WB_rob_idx(WB_rob_idx),
    .writeback_free(writeback_free), .grant_oh(grant_oh)
  );

  task automatic idle();
    req_valid = '0; req_data = '0; req_rob_idx = '0;
    mispredict = 1'b0; flush_mask = '0;
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [IW-1:0] x);
    req_valid[i] = 1'b1;
    req_data[32*i +: 32] = d;
    req_rob_idx[IW*i +: IW] = x;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1; idle();
  endtask

  // Leaves the bench 1ns into "cycle 1": first cycle with rst low.
  task automatic do_reset();
    idle(); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL rst_wbv got=%0b exp=0", WB_valid); bad++; end
    total++; if (grant_oh !== 4'b0000) begin $display("FAIL rst_grant got=%b exp=0000", grant_oh); bad++; end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b1111) begin $display("FAIL rst_ready got=%b exp=1111", req_ready); bad++; end
    total++; if (writeback_free !== 1'b1) begin $display("FAIL rst_free got=%0b exp=1", writeback_free); bad++; end
    total++; if (WB_data !== 32'h0 || WB_rob_idx !== 4'h0) begin $display("FAIL rst_wbzero got=%h/%h exp=0/0", WB_data, WB_rob_idx); bad++; end
  endtask

  task automatic test_single();
    do_reset();
    send(0, 32'hA5A5, 4'd3);
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t1_c1_wbv got=%0b exp=0", WB_valid); bad++; end
    total++; if (writeback_free !== 1'b0) begin $display("FAIL t1_c1_free got=%0b exp=0", writeback_free); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (WB_valid !== 1'b1 || WB_rob_idx !== 4'd3 || WB_data !== 32'hA5A5)
      begin $display("FAIL t1_c2_wb got=%0b/%0d/%h exp=1/3/a5a5", WB_valid, WB_rob_idx, WB_data); bad++; end
    total++; if (writeback_free !== 1'b1) begin $display("FAIL t1_c2_free got=%0b exp=1", writeback_free); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t1_c3_wbv got=%0b exp=0", WB_valid); bad++; end
  endtask

  task automatic test_all_four();
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < N; i++) send(i, 32'h100 + i, IW'(i + 1));
    @(negedge clk);
    total++; if (req_ready !== 4'b1111) begin $display("FAIL t2_c1_ready got=%b exp=1111", req_ready); bad++; end
    next_cycle();
    send(0, 32'h200, 4'd7);
    @(negedge clk);
    total++; if (grant_oh !== 4'b0001 || WB_data !== 32'h100)
      begin $display("FAIL t2_c2_grant got=%b/%h exp=0001/100", grant_oh, WB_data); bad++; end
    total++; if (req_ready !== 4'b0001) begin $display("FAIL t2_allfull_ready got=%b exp=0001", req_ready); bad++; end
    for (int k = 1; k < N; k++) begin
      next_cycle();
      @(negedge clk);
      eg = '0; eg[k] = 1'b1;
      total++; if (grant_oh !== eg || WB_data !== 32'h100 + k || WB_rob_idx !== IW'(k + 1))
        begin $display("FAIL t2_order%0d got=%b/%h/%0d exp=%b/%h/%0d", k, grant_oh, WB_data, WB_rob_idx, eg, 32'h100 + k, k + 1); bad++; end
    end
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b0001 || WB_data !== 32'h200 || WB_rob_idx !== 4'd7)
      begin $display("FAIL t2_resend got=%b/%h/%0d exp=0001/200/7", grant_oh, WB_data, WB_rob_idx); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t2_drain got=%0b exp=0", WB_valid); bad++; end
  endtask

  task automatic test_wrap();
    do_reset();
    send(2, 32'h22, 4'd1);
    next_cycle();                         // FU2 granted here -> rr_ptr=3
    next_cycle();
    send(2, 32'h2B, 4'd2); send(3, 32'h3B, 4'd3);
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b1000) begin $display("FAIL t3_first got=%b exp=1000", grant_oh); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b0100 || WB_data !== 32'h2B)
      begin $display("FAIL t3_second got=%b/%h exp=0100/2b", grant_oh, WB_data); bad++; end
    next_cycle();
    send(0, 32'h0C, 4'd4); send(3, 32'h3C, 4'd5);
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b1000) begin $display("FAIL t3_ptr3 got=%b exp=1000", grant_oh); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b0001) begin $display("FAIL t3_after got=%b exp=0001", grant_oh); bad++; end
  endtask

  task automatic test_kill();
    do_reset();
    send(0, 32'h99, 4'd9); send(1, 32'h55, 4'd5);
    next_cycle();
    mispredict = 1'b1; flush_mask = 16'h0200;
    send(2, 32'h999, 4'd9); send(3, 32'h44, 4'd4);
    @(negedge clk);
    total++; if (grant_oh !== 4'b0010 || WB_rob_idx !== 4'd5 || WB_data !== 32'h55)
      begin $display("FAIL t4_grant got=%b/%0d/%h exp=0010/5/55", grant_oh, WB_rob_idx, WB_data); bad++; end
    total++; if (req_ready !== 4'b1110) begin $display("FAIL t4_ready got=%b exp=1110", req_ready); bad++; end
    total++; if (writeback_free !== 1'b0) begin $display("FAIL t4_free got=%0b exp=0", writeback_free); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b1000 || WB_rob_idx !== 4'd4)
      begin $display("FAIL t4_survivor got=%b/%0d exp=1000/4", grant_oh, WB_rob_idx); bad++; end
    total++; if (writeback_free !== 1'b1) begin $display("FAIL t4_free2 got=%0b exp=1", writeback_free); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t4_nokilled got=%0b/%0d exp=0", WB_valid, WB_rob_idx); bad++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(1, 32'h11, 4'd2);
    next_cycle();
    send(1, 32'h22, 4'd3);
    @(negedge clk);
    total++; if (grant_oh !== 4'b0010 || WB_data !== 32'h11)
      begin $display("FAIL t5_grant got=%b/%h exp=0010/11", grant_oh, WB_data); bad++; end
    total++; if (req_ready[1] !== 1'b1) begin $display("FAIL t5_ready1 got=%0b exp=1", req_ready[1]); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (WB_valid !== 1'b1 || WB_data !== 32'h22 || WB_rob_idx !== 4'd3)
      begin $display("FAIL t5_nobubble got=%0b/%h/%0d exp=1/22/3", WB_valid, WB_data, WB_rob_idx); bad++; end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) send(i, 32'h300 + i, IW'(i + 8));
    next_cycle();                         // FU0 granted, 3 slots left held, rr_ptr=1
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t6_rstcyc got=%0b exp=0", WB_valid); bad++; end
    @(posedge clk); #1; rst = 1'b0;
    send(0, 32'h40, 4'd1); send(3, 32'h43, 4'd2);
    @(negedge clk);
    total++; if (WB_valid !== 1'b0) begin $display("FAIL t6_after got=%0b exp=0", WB_valid); bad++; end
    total++; if (req_ready !== 4'b1111) begin $display("FAIL t6_ready got=%b exp=1111", req_ready); bad++; end
    next_cycle();
    @(negedge clk);
    total++; if (grant_oh !== 4'b0001 || WB_data !== 32'h40)
      begin $display("FAIL t6_ptr0 got=%b/%h exp=0001/40", grant_oh, WB_data); bad++; end
  endtask

  // Random traffic against a slot-array reference model of the arbitration rules.
  task automatic test_random();
    bit            mh [N];
    logic [31:0]   md [N];
    logic [IW-1:0] mi [N];
    int            mp;
    bit            kill [N];
    bit            ld [N];
    int            g, p;
    logic [N-1:0]  eg, er;
    logic [31:0]   ed;
    logic [IW-1:0] ei;
    logic [IW-1:0] inidx;
    bit            ef;
    do_reset();
    mp = 0;
    for (int i = 0; i < N; i++) begin mh[i] = 0; md[i] = '0; mi[i] = '0; end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) < 6) send(i, $urandom, IW'($urandom_range(0, RL - 1)));
      mispredict = ($urandom_range(0, 7) == 0);
      flush_mask = RL'($urandom & $urandom & $urandom);
      @(negedge clk);
      for (int i = 0; i < N; i++) kill[i] = mispredict && mh[i] && flush_mask[mi[i]];
      g = -1;
      for (int k = 0; k < N; k++) begin
        p = (mp + k) % N;
        if (g < 0 && mh[p] && !kill[p]) g = p;
      end
      eg = '0; ed = '0; ei = '0; ef = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i == g) begin eg[i] = 1'b1; ed = md[i]; ei = mi[i]; end
        er[i] = !mh[i] || (i == g);
        inidx = req_rob_idx[IW*i +: IW];
        ld[i] = req_valid[i] && er[i] && !(mispredict && flush_mask[inidx]);
        if (ld[i] || (mh[i] && !kill[i] && i != g)) ef = 1'b0;
      end
      total++; if (grant_oh !== eg) begin $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant_oh, eg); bad++; end
      total++; if (WB_valid !== (g >= 0)) begin $display("FAIL rnd_wbv c=%0d got=%0b exp=%0b", c, WB_valid, g >= 0); bad++; end
      total++; if (WB_data !== ed) begin $display("FAIL rnd_data c=%0d got=%h exp=%h", c, WB_data, ed); bad++; end
      total++; if (WB_rob_idx !== ei) begin $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, WB_rob_idx, ei); bad++; end
      total++; if (req_ready !== er) begin $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, er); bad++; end
      total++; if (writeback_free !== ef) begin $display("FAIL rnd_free c=%0d got=%0b exp=%0b", c, writeback_free, ef); bad++; end
      for (int i = 0; i < N; i++) begin
        if (ld[i]) begin
          mh[i] = 1; md[i] = req_data[32*i +: 32]; mi[i] = req_rob_idx[IW*i +: IW];
        end else if (i == g || kill[i]) begin
          mh[i] = 0;
        end
      end
      if (g >= 0) mp = (g + 1) % N;
      next_cycle();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
